pad_cfg_shifter: RTL and testbench
==================================

PAD_CFG_SHIFTER -- requirements
Module: pad_cfg_shifter

Interface
REQ-001 SHALL have parameter N_PADS, default 32, number of pads in the configuration chain.
REQ-002 SHALL have parameter CFG_W, default 6, configuration bits per pad (PD, PU, SMT, SR, PIN1, PIN2 at bits 0..5).
REQ-003 SHALL have parameter CLK_DIV, default 4, serial clock half-period in HCLK cycles, legal range 1..255.
REQ-004 SHALL have port HCLK  input  1  system clock; all state updates on its rising edge.
REQ-005 SHALL have port HRESETn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port pad_cfg_i  input  N_PADS*CFG_W  packed pad configuration {pad[N_PADS-1] .. pad[0]}, driven by the APB control-register block.
REQ-007 SHALL have port force_i  input  1  single-cycle request to resend the configuration even when unchanged.
REQ-008 SHALL have port cfg_sclk_o  output  1  serial chain clock to the pad ring.
REQ-009 SHALL have port cfg_sdata_o  output  1  serial chain data.
REQ-010 SHALL have port cfg_latch_o  output  1  pad-ring update strobe.
REQ-011 SHALL have port busy_o  output  1  transfer in progress.
REQ-012 SHALL have port done_o  output  1  one-cycle pulse when a transfer completes.

Function
REQ-013 SHALL register all outputs; no combinational path from any input to any output.
REQ-014 SHALL implement states IDLE, SHIFT and LATCH.
REQ-015 SHALL keep a shadow register holding the last configuration captured for transfer.
REQ-016 SHALL, in IDLE, start a transfer when pad_cfg_i differs from the shadow register, or force_pend is set, or init_pend is set.
REQ-017 SHALL, in the start cycle T, copy pad_cfg_i into the shadow register and the shift register, clear force_pend and init_pend, and enter SHIFT at T+1.
REQ-018 SHALL shift MSB first: bit N_PADS*CFG_W-1 first, bit 0 last.
REQ-019 SHALL, per bit, hold cfg_sclk_o low for CLK_DIV cycles and then high for CLK_DIV cycles.
REQ-020 SHALL change cfg_sdata_o only in the cycle in which cfg_sclk_o goes low; the first bit is valid at T+1.
REQ-021 SHALL, after the high phase of bit 0, enter LATCH: cfg_sclk_o=0, cfg_sdata_o=0, cfg_latch_o=1 for CLK_DIV cycles, then return to IDLE.
REQ-022 SHALL assert busy_o in SHIFT and LATCH only; busy duration SHALL be exactly 2*CLK_DIV*N_PADS*CFG_W + CLK_DIV cycles (1540 for the defaults).
REQ-023 SHALL assert done_o for exactly the first IDLE cycle after LATCH.
REQ-024 SHALL evaluate the start condition in the done_o cycle, so back-to-back transfers are separated by one idle cycle.
REQ-025 SHALL ignore pad_cfg_i changes during SHIFT and LATCH; the captured snapshot is shipped unchanged, and any remaining difference triggers a new transfer from IDLE.
REQ-026 SHALL latch a force_i pulse seen in any state into force_pend, served at the next IDLE evaluation; multiple pulses collapse into one resend.
REQ-027 SHALL use a bit counter sized ceil(log2(N_PADS*CFG_W+1)) and a divider counter of 8 bits, with no wrap-around inside a transfer.
REQ-028 SHALL hold cfg_sclk_o=0, cfg_sdata_o=0 and cfg_latch_o=0 in IDLE.

Reset
REQ-029 SHALL, while HRESETn=0, immediately force state=IDLE, all outputs 0, shadow and shift registers 0, force_pend=0 and init_pend=1.
REQ-030 SHALL, on reset mid-transfer, abandon the transfer with no latch pulse and, after release, ship the current pad_cfg_i once via init_pend.

Verification
REQ-031 Release reset with pad_cfg_i=0 and CLK_DIV=2 -> one transfer, 192 zero bits, busy_o high for 770 cycles, cfg_latch_o high for 2 cycles, then done_o pulses once.
REQ-032 Write pad[31]=6'h3F, others 0, CLK_DIV=2 -> first 6 sampled bits (on cfg_sclk_o rising edges) are 1, remaining 186 bits are 0, then the latch pulse.
REQ-033 Change pad[0] to 6'h01 at SHIFT bit 100 -> current transfer ships the old value; a second transfer starts 1 cycle after done_o and its last bit is 1.
REQ-034 Pulse force_i twice in IDLE with no change -> exactly one resend of identical data.
REQ-035 Assert HRESETn low at bit 50 -> all outputs 0 immediately with no latch pulse; after release, a full transfer of the current pad_cfg_i runs.
REQ-036 CLK_DIV=1, alternating pattern 0xAAA.. -> cfg_sclk_o toggles every cycle, busy_o high for 385 cycles, and the captured bits match the pattern.

Source files
------------

// File: rtl/pad_cfg_shifter.sv
// rtl/pad_cfg_shifter.sv - serialises the packed pad configuration into the pad-ring chain
module pad_cfg_shifter #(
  parameter int N_PADS  = 32,
  parameter int CFG_W   = 6,
  parameter int CLK_DIV = 4
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic [N_PADS*CFG_W-1:0]   pad_cfg_i,
  input  logic                      force_i,
  output logic                      cfg_sclk_o,
  output logic                      cfg_sdata_o,
  output logic                      cfg_latch_o,
  output logic                      busy_o,
  output logic                      done_o
);

  localparam int TOTAL = N_PADS * CFG_W;
  localparam int BCW   = $clog2(TOTAL + 1);
  localparam logic [7:0]     DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [BCW-1:0] BITS     = BCW'(TOTAL);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

  state_t             state, state_nxt;
  logic [TOTAL-1:0]   shadow, shadow_nxt;
  logic [TOTAL-1:0]   shreg, shreg_nxt;
  logic [BCW-1:0]     bit_cnt, bit_cnt_nxt;
  logic [7:0]         div_cnt, div_cnt_nxt;
  logic               force_pend, force_pend_nxt;
  logic               init_pend, init_pend_nxt;
  logic               sclk_nxt, sdata_nxt, latch_nxt, busy_nxt, done_nxt;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state       <= IDLE;
      shadow      <= '0;
      shreg       <= '0;
      bit_cnt     <= '0;
      div_cnt     <= '0;
      force_pend  <= 1'b0;
      init_pend   <= 1'b1;
      cfg_sclk_o  <= 1'b0;
      cfg_sdata_o <= 1'b0;
      cfg_latch_o <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      state       <= state_nxt;
      shadow      <= shadow_nxt;
      shreg       <= shreg_nxt;
      bit_cnt     <= bit_cnt_nxt;
      div_cnt     <= div_cnt_nxt;
      force_pend  <= force_pend_nxt;
      init_pend   <= init_pend_nxt;
      cfg_sclk_o  <= sclk_nxt;
      cfg_sdata_o <= sdata_nxt;
      cfg_latch_o <= latch_nxt;
      busy_o      <= busy_nxt;
      done_o      <= done_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    shadow_nxt     = shadow;
    shreg_nxt      = shreg;
    bit_cnt_nxt    = bit_cnt;
    div_cnt_nxt    = div_cnt;
    force_pend_nxt = force_pend | force_i;
    init_pend_nxt  = init_pend;
    sclk_nxt       = cfg_sclk_o;
    sdata_nxt      = cfg_sdata_o;
    latch_nxt      = cfg_latch_o;
    busy_nxt       = busy_o;
    done_nxt       = 1'b0;

    case (state)
      IDLE: begin
        sclk_nxt  = 1'b0;
        sdata_nxt = 1'b0;
        latch_nxt = 1'b0;
        busy_nxt  = 1'b0;
        if ((pad_cfg_i != shadow) || force_pend || init_pend) begin
          // A force pulse arriving in the start cycle is covered by this snapshot.
          state_nxt      = SHIFT;
          shadow_nxt     = pad_cfg_i;
          shreg_nxt      = pad_cfg_i << 1;
          sdata_nxt      = pad_cfg_i[TOTAL-1];
          busy_nxt       = 1'b1;
          bit_cnt_nxt    = BITS;
          div_cnt_nxt    = '0;
          force_pend_nxt = 1'b0;
          init_pend_nxt  = 1'b0;
        end
      end

      SHIFT: begin
        if (div_cnt == DIV_LAST) begin
          div_cnt_nxt = '0;
          if (!cfg_sclk_o) begin
            sclk_nxt = 1'b1;
          end else begin
            bit_cnt_nxt = bit_cnt - BCW'(1);
            sclk_nxt    = 1'b0;
            if (bit_cnt == BCW'(1)) begin
              state_nxt = LATCH;
              sdata_nxt = 1'b0;
              latch_nxt = 1'b1;
            end else begin
              sdata_nxt = shreg[TOTAL-1];
              shreg_nxt = shreg << 1;
            end
          end
        end else begin
          div_cnt_nxt = div_cnt + 8'd1;
        end
      end

      LATCH: begin
        if (div_cnt == DIV_LAST) begin
          div_cnt_nxt = '0;
          state_nxt   = IDLE;
          latch_nxt   = 1'b0;
          busy_nxt    = 1'b0;
          done_nxt    = 1'b1;
        end else begin
          div_cnt_nxt = div_cnt + 8'd1;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pad_cfg_shifter.sv
// tb/tb_pad_cfg_shifter.sv - directed self-checking bench for pad_cfg_shifter
module tb_pad_cfg_shifter;

  localparam logic [191:0] P32 = {6'h3F, 186'b0};
  localparam logic [191:0] PB  = P32 | 192'd1;
  localparam logic [191:0] PC  = {32{6'h15}};
  localparam logic [191:0] PD  = {32{6'h2A}};
  localparam logic [191:0] PAT = {48{4'hA}};

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  logic [191:0] pad2 = '0, pad1 = '0;
  logic force2 = 1'b0, force1 = 1'b0;
  logic sclk2, sdata2, latch2, busy2, done2;
  logic sclk1, sdata1, latch1, busy1, done1;
  logic [1:0] sclk_v, sdata_v, latch_v, busy_v, done_v;
  int checks = 0, errors = 0;

  always #5 HCLK = ~HCLK;

  pad_cfg_shifter #(.CLK_DIV(2)) u_dut2 (
    .HCLK(HCLK), .HRESETn(HRESETn), .pad_cfg_i(pad2), .force_i(force2),
    .cfg_sclk_o(sclk2), .cfg_sdata_o(sdata2), .cfg_latch_o(latch2),
    .busy_o(busy2), .done_o(done2));

  pad_cfg_shifter #(.CLK_DIV(1)) u_dut1 (
    .HCLK(HCLK), .HRESETn(HRESETn), .pad_cfg_i(pad1), .force_i(force1),
    .cfg_sclk_o(sclk1), .cfg_sdata_o(sdata1), .cfg_latch_o(latch1),
    .busy_o(busy1), .done_o(done1));

  assign sclk_v  = {sclk2, sclk1};
  assign sdata_v = {sdata2, sdata1};
  assign latch_v = {latch2, latch1};
  assign busy_v  = {busy2, busy1};
  assign done_v  = {done2, done1};

  // Called just after a falling edge; returns on the done cycle (or right after the reset hit).
  task automatic capture(input int w, input int action, input int at_bit, input logic [191:0] new_val,
                         output logic [191:0] cap, output int busy_cnt, output int latch_cnt,
                         output int rises, output int toggles, output int idle_wait,
                         output int viol, output logic done_end);
    logic ps, pd, fired;
    int guard;
    cap = '0; busy_cnt = 0; latch_cnt = 0; rises = 0; toggles = 0; idle_wait = 0; viol = 0;
    done_end = 1'b0; ps = 1'b0; pd = 1'b0; fired = 1'b0; guard = 0;
    while (!busy_v[w] && guard < 2000) begin
      idle_wait++; guard++;
      @(negedge HCLK);
    end
    if (!busy_v[w]) begin
      checks++; errors++;
      $display("FAIL capture_start: busy_o=0 required 1 after %0d cycles", guard);
      return;
    end
    guard = 0;
    while (busy_v[w] && guard < 4000) begin
      busy_cnt++; guard++;
      if (sclk_v[w] != ps) toggles++;
      if (sclk_v[w] && !ps) begin
        cap = {cap[190:0], sdata_v[w]};
        rises++;
      end
      if (latch_v[w]) begin
        latch_cnt++;
        if (sclk_v[w] || sdata_v[w]) viol++;
      end
      if (done_v[w]) viol++;
      if (busy_cnt > 1 && sdata_v[w] != pd && !(ps && !sclk_v[w])) viol++;
      ps = sclk_v[w];
      pd = sdata_v[w];
      if (action == 1 && !fired && rises == at_bit) begin
        if (w == 1) pad2 = new_val; else pad1 = new_val;
        fired = 1'b1;
      end
      if (action == 2 && rises == at_bit) begin
        HRESETn = 1'b0;
        return;
      end
      @(negedge HCLK);
    end
    if (busy_v[w]) begin
      checks++; errors++;
      $display("FAIL capture_end: busy_o still 1 after %0d cycles", guard);
    end
    done_end = done_v[w];
  endtask

  task automatic test_reset();
    repeat (3) @(negedge HCLK);
    checks++; if (sclk2 !== 1'b0)  begin errors++; $display("FAIL reset_sclk: got %b expected 0", sclk2); end
    checks++; if (sdata2 !== 1'b0) begin errors++; $display("FAIL reset_sdata: got %b expected 0", sdata2); end
    checks++; if (latch2 !== 1'b0) begin errors++; $display("FAIL reset_latch: got %b expected 0", latch2); end
    checks++; if (busy2 !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b expected 0", busy2); end
    checks++; if (done2 !== 1'b0)  begin errors++; $display("FAIL reset_done: got %b expected 0", done2); end
    checks++; if (busy1 !== 1'b0)  begin errors++; $display("FAIL reset_busy1: got %b expected 0", busy1); end
    HRESETn = 1'b1;
  endtask

  task automatic test_init();
    logic [191:0] cap; int bc, lc, rs, tg, iw, vi; logic de;
    capture(1, 0, 0, '0, cap, bc, lc, rs, tg, iw, vi, de);
    checks++; if (cap !== '0) begin errors++; $display("FAIL init_data: got %h expected 0", cap); end
    checks++; if (rs != 192)  begin errors++; $display("FAIL init_bits: got %0d expected 192", rs); end
    checks++; if (bc != 770)  begin errors++; $display("FAIL init_busy: got %0d expected 770", bc); end
    checks++; if (lc != 2)    begin errors++; $display("FAIL init_latch: got %0d expected 2", lc); end
    checks++; if (vi != 0)    begin errors++; $display("FAIL init_protocol: got %0d violations expected 0", vi); end
    checks++; if (de !== 1'b1) begin errors++; $display("FAIL init_done: got %b expected 1", de); end
    @(negedge HCLK);
    checks++; if (done2 !== 1'b0 || busy2 !== 1'b0)
      begin errors++; $display("FAIL init_after: done=%b busy=%b expected 0 0", done2, busy2); end
  endtask

  task automatic test_pattern();
    logic [191:0] cap; int bc, lc, rs, tg, iw, vi; logic de;
    pad2 = P32;
    capture(1, 0, 0, '0, cap, bc, lc, rs, tg, iw, vi, de);
    checks++; if (cap !== P32) begin errors++; $display("FAIL pattern_data: got %h expected %h", cap, P32); end
    checks++; if (bc != 770 || lc != 2)
      begin errors++; $display("FAIL pattern_timing: busy %0d latch %0d expected 770 2", bc, lc); end
    checks++; if (vi != 0 || de !== 1'b1)
      begin errors++; $display("FAIL pattern_protocol: viol %0d done %b expected 0 1", vi, de); end
    repeat (10) @(negedge HCLK);
    checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL pattern_idle: busy %b expected 0", busy2); end
  endtask

  task automatic test_back_to_back();
    logic [191:0] cap; int bc, lc, rs, tg, iw, vi; logic de;
    force2 = 1'b1;
    @(negedge HCLK);
    force2 = 1'b0;
    capture(1, 1, 100, PB, cap, bc, lc, rs, tg, iw, vi, de);
    checks++; if (cap !== P32) begin errors++; $display("FAIL b2b_first_data: got %h expected %h", cap, P32); end
    checks++; if (de !== 1'b1) begin errors++; $display("FAIL b2b_first_done: got %b expected 1", de); end
    capture(1, 0, 0, '0, cap, bc, lc, rs, tg, iw, vi, de);
    checks++; if (iw != 1)     begin errors++; $display("FAIL b2b_gap: got %0d idle cycles expected 1", iw); end
    checks++; if (cap !== PB)  begin errors++; $display("FAIL b2b_second_data: got %h expected %h", cap, PB); end
    checks++; if (bc != 770 || de !== 1'b1)
      begin errors++; $display("FAIL b2b_second_timing: busy %0d done %b expected 770 1", bc, de); end
  endtask

  task automatic test_force();
    logic [191:0] cap; int bc, lc, rs, tg, iw, vi; logic de; int extra;
    repeat (5) @(negedge HCLK);
    checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL force_pre_idle: busy %b expected 0", busy2); end
    force2 = 1'b1;
    @(negedge HCLK);
    fork
      begin @(negedge HCLK); force2 = 1'b0; end
    join_none
    capture(1, 0, 0, '0, cap, bc, lc, rs, tg, iw, vi, de);
    checks++; if (cap !== PB || bc != 770)
      begin errors++; $display("FAIL force_data: got %h busy %0d expected %h 770", cap, bc, PB); end
    extra = 0;
    repeat (30) begin
      @(negedge HCLK);
      if (busy2) extra++;
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL force_single: got %0d extra busy cycles expected 0", extra); end
  endtask

  task automatic test_reset_mid();
    logic [191:0] cap; int bc, lc, rs, tg, iw, vi; logic de;
    pad2 = PC;
    capture(1, 2, 50, '0, cap, bc, lc, rs, tg, iw, vi, de);
    #1;
    checks++; if (rs != 50) begin errors++; $display("FAIL rst_at_bit: got %0d expected 50", rs); end
    checks++; if ({sclk2, sdata2, latch2, busy2, done2} !== 5'b0)
      begin errors++; $display("FAIL rst_outputs: got %b expected 00000", {sclk2, sdata2, latch2, busy2, done2}); end
    checks++; if (lc != 0) begin errors++; $display("FAIL rst_no_latch: got %0d expected 0", lc); end
    pad2 = PD;
    repeat (2) @(negedge HCLK);
    checks++; if (latch2 !== 1'b0 || busy2 !== 1'b0)
      begin errors++; $display("FAIL rst_hold: latch %b busy %b expected 0 0", latch2, busy2); end
    HRESETn = 1'b1;
    capture(1, 0, 0, '0, cap, bc, lc, rs, tg, iw, vi, de);
    checks++; if (cap !== PD) begin errors++; $display("FAIL rst_resend_data: got %h expected %h", cap, PD); end
    checks++; if (bc != 770 || lc != 2 || de !== 1'b1)
      begin errors++; $display("FAIL rst_resend_timing: busy %0d latch %0d done %b expected 770 2 1", bc, lc, de); end
  endtask

  task automatic test_clkdiv1();
    logic [191:0] cap; int bc, lc, rs, tg, iw, vi; logic de;
    @(negedge HCLK);
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL div1_pre_idle: busy %b expected 0", busy1); end
    pad1 = PAT;
    capture(0, 0, 0, '0, cap, bc, lc, rs, tg, iw, vi, de);
    checks++; if (cap !== PAT) begin errors++; $display("FAIL div1_data: got %h expected %h", cap, PAT); end
    checks++; if (bc != 385)   begin errors++; $display("FAIL div1_busy: got %0d expected 385", bc); end
    checks++; if (tg != 384)   begin errors++; $display("FAIL div1_toggles: got %0d expected 384", tg); end
    checks++; if (lc != 1 || rs != 192)
      begin errors++; $display("FAIL div1_latch_bits: latch %0d bits %0d expected 1 192", lc, rs); end
    checks++; if (vi != 0 || de !== 1'b1)
      begin errors++; $display("FAIL div1_protocol: viol %0d done %b expected 0 1", vi, de); end
  endtask

  initial begin
    test_reset();
    test_init();
    test_pattern();
    test_back_to_back();
    test_force();
    test_reset_mid();
    test_clkdiv1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
